// File: rtl/lsf_bus_const_pkg.sv
// Bus widths shared between the HPS, the sector-logic processor and the LSF.
package lsf_bus_const_pkg;
    localparam int HPS_LSF_LEN        = 32;
    localparam int SLCPROC_HPS_SF_LEN = 48;
endpackage

// File: rtl/lsf_input_feeder_pkg.sv
// LSF-side constants and helpers for the input feeder that buffers hits and ROIs.
package lsf_input_feeder_pkg;
    localparam int LSF_FEED_HIT_DEPTH = 32;
    localparam int LSF_FEED_ROI_DEPTH = 4;

    localparam int                 EV_CNT_W   = 10;
    localparam logic [EV_CNT_W-1:0] EV_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ERR_HIT_OVF = 2'd0,
        ERR_ROI_OVF = 2'd1,
        ERR_HIT_UDF = 2'd2,
        ERR_ROI_UDF = 2'd3
    } err_bit_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/lsf_fwft_fifo.sv
// First-word-fall-through FIFO: head word is visible whenever empty is low,
// a read pops on the same edge. DEPTH must be a power of two, at least 2.
module lsf_fwft_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty     = (occ_q == '0);
    assign full      = (occ_q == (AW+1)'(DEPTH));
    assign do_rd     = rd_en && !empty;
    // A full buffer still takes a write when the head is popped on the same edge.
    assign do_wr     = wr_en && (!full || do_rd);
    assign overflow  = wr_en && !do_wr;
    assign underflow = rd_en && empty;
    assign rd_data   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: rd_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/lsf_input_feeder.sv
// Buffers MDT hits and ROIs for the LSF, enforcing a per-event hit cap and
// keeping drop/error statistics.
module lsf_input_feeder
    import lsf_bus_const_pkg::*;
    import lsf_input_feeder_pkg::*;
#(
    parameter int HIT_DEPTH = LSF_FEED_HIT_DEPTH,
    parameter int ROI_DEPTH = LSF_FEED_ROI_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          srst,
    input  logic [HPS_LSF_LEN-1:0]        hit_in,
    input  logic                          hit_in_vld,
    input  logic                          hit_in_last,
    input  logic [SLCPROC_HPS_SF_LEN-1:0] roi_in,
    input  logic                          roi_in_vld,
    input  logic [EV_CNT_W-1:0]           hit_cap,
    output logic [HPS_LSF_LEN-1:0]        mdt_hit,
    output logic                          mdt_hit_empty,
    input  logic                          mdt_hit_re,
    output logic [SLCPROC_HPS_SF_LEN-1:0] roi,
    output logic                          roi_empty,
    input  logic                          roi_re,
    output logic [15:0]                   hit_drop_cnt,
    output logic [3:0]                    err_flags
);
    logic [1:0]          rst_sync_q;
    logic                rst_n_int;
    logic [EV_CNT_W-1:0] ev_cnt_q, ev_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [3:0]          err_q, err_d;
    logic                cap_drop, hit_wr;
    logic                hit_ovf, hit_udf, roi_ovf, roi_udf;
    logic                hit_full_unused, roi_full_unused;

    // Assert asynchronously, release two edges after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    assign cap_drop = hit_in_vld && (hit_cap != '0) && (ev_cnt_q >= hit_cap);
    assign hit_wr   = hit_in_vld && !cap_drop;

    lsf_fwft_fifo #(.WIDTH(HPS_LSF_LEN), .DEPTH(HIT_DEPTH)) u_hit_fifo (
        .clk       (clk),
        .rst_n     (rst_n_int),
        .srst      (srst),
        .wr_en     (hit_wr),
        .wr_data   (hit_in),
        .rd_en     (mdt_hit_re),
        .rd_data   (mdt_hit),
        .full      (hit_full_unused),
        .empty     (mdt_hit_empty),
        .overflow  (hit_ovf),
        .underflow (hit_udf)
    );

    lsf_fwft_fifo #(.WIDTH(SLCPROC_HPS_SF_LEN), .DEPTH(ROI_DEPTH)) u_roi_fifo (
        .clk       (clk),
        .rst_n     (rst_n_int),
        .srst      (srst),
        .wr_en     (roi_in_vld),
        .wr_data   (roi_in),
        .rd_en     (roi_re),
        .rd_data   (roi),
        .full      (roi_full_unused),
        .empty     (roi_empty),
        .overflow  (roi_ovf),
        .underflow (roi_udf)
    );

    always_comb begin
        ev_cnt_d = ev_cnt_q;
        if (hit_in_vld) begin
            if (hit_in_last)                ev_cnt_d = '0;
            else if (ev_cnt_q != EV_CNT_MAX) ev_cnt_d = ev_cnt_q + EV_CNT_W'(1);
        end
        // A hit that is both over the cap and hits a full buffer counts once.
        drop_cnt_d = (cap_drop || hit_ovf) ? sat_inc16(drop_cnt_q) : drop_cnt_q;
        err_d = err_q;
        err_d[ERR_HIT_OVF] = err_q[ERR_HIT_OVF] | hit_ovf;
        err_d[ERR_ROI_OVF] = err_q[ERR_ROI_OVF] | roi_ovf;
        err_d[ERR_HIT_UDF] = err_q[ERR_HIT_UDF] | hit_udf;
        err_d[ERR_ROI_UDF] = err_q[ERR_ROI_UDF] | roi_udf;
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            ev_cnt_q   <= '0;
            drop_cnt_q <= '0;
            err_q      <= '0;
        end else if (srst) begin
            ev_cnt_q   <= '0;
            drop_cnt_q <= '0;
            err_q      <= '0;
        end else begin
            ev_cnt_q   <= ev_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_q      <= err_d;
        end
    end

    assign hit_drop_cnt = drop_cnt_q;
    assign err_flags    = err_q;
endmodule

// File: tb/tb_lsf_input_feeder.sv
// Scoreboard bench for lsf_input_feeder: directed stimulus queues expected
// words, negedge monitors compare every popped word.
module tb_lsf_input_feeder;
    import lsf_bus_const_pkg::*;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          srst = 1'b0;
    logic [HPS_LSF_LEN-1:0]        hit_in = '0;
    logic                          hit_in_vld = 1'b0;
    logic                          hit_in_last = 1'b0;
    logic [SLCPROC_HPS_SF_LEN-1:0] roi_in = '0;
    logic                          roi_in_vld = 1'b0;
    logic [9:0]                    hit_cap = '0;
    logic [HPS_LSF_LEN-1:0]        mdt_hit;
    logic                          mdt_hit_empty;
    logic                          mdt_hit_re = 1'b0;
    logic [SLCPROC_HPS_SF_LEN-1:0] roi;
    logic                          roi_empty;
    logic                          roi_re = 1'b0;
    logic [15:0]                   hit_drop_cnt;
    logic [3:0]                    err_flags;

    int n_tests = 0;
    int n_fail  = 0;
    logic [HPS_LSF_LEN-1:0]        hit_q [$];
    logic [SLCPROC_HPS_SF_LEN-1:0] roi_q [$];

    lsf_input_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .srst          (srst),
        .hit_in        (hit_in),
        .hit_in_vld    (hit_in_vld),
        .hit_in_last   (hit_in_last),
        .roi_in        (roi_in),
        .roi_in_vld    (roi_in_vld),
        .hit_cap       (hit_cap),
        .mdt_hit       (mdt_hit),
        .mdt_hit_empty (mdt_hit_empty),
        .mdt_hit_re    (mdt_hit_re),
        .roi           (roi),
        .roi_empty     (roi_empty),
        .roi_re        (roi_re),
        .hit_drop_cnt  (hit_drop_cnt),
        .err_flags     (err_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_srst();
        srst = 1'b1;
        hit_in_vld = 1'b1;
        hit_in = 32'hDEAD;
        cyc();
        srst = 1'b0;
        hit_in_vld = 1'b0;
    endtask

    task automatic drain_hits();
        mdt_hit_re = 1'b1;
        for (int k = 0; k < 100 && !mdt_hit_empty; k++) cyc();
        mdt_hit_re = 1'b0;
        chk("hit_drained_empty", mdt_hit_empty, 1);
    endtask

    task automatic drain_rois();
        roi_re = 1'b1;
        for (int k = 0; k < 20 && !roi_empty; k++) cyc();
        roi_re = 1'b0;
        chk("roi_drained_empty", roi_empty, 1);
    endtask

    always @(negedge clk) begin
        if (rst && mdt_hit_re && !mdt_hit_empty) begin
            if (hit_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL hit_unexpected: got 0x%0h, expected no word", mdt_hit);
            end else begin
                chk("hit_data", mdt_hit, hit_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst && roi_re && !roi_empty) begin
            if (roi_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL roi_unexpected: got 0x%0h, expected no word", roi);
            end else begin
                chk("roi_data", roi, roi_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b0;
        #1;
        chk("rst_hit_empty", mdt_hit_empty, 1);
        chk("rst_roi_empty", roi_empty, 1);
        chk("rst_mdt_hit", mdt_hit, 0);
        chk("rst_roi", roi, 0);
        chk("rst_drop_cnt", hit_drop_cnt, 0);
        chk("rst_err", err_flags, 0);
        cyc(); cyc();
        rst = 1'b1;
        cyc(); cyc(); cyc();

        // Three back-to-back hits with re held; the first re hits an empty buffer.
        mdt_hit_re = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            hit_in = HPS_LSF_LEN'(i);
            hit_in_vld = 1'b1;
            hit_q.push_back(HPS_LSF_LEN'(i));
            cyc();
        end
        hit_in_vld = 1'b0;
        cyc();
        chk("fwft_empty_cycle4", mdt_hit_empty, 1);
        mdt_hit_re = 1'b0;
        chk("fwft_queue_drained", hit_q.size(), 0);
        chk("hit_udf_flag", err_flags[2], 1);

        // ROI underflow, then overflow on a 4-deep buffer.
        roi_re = 1'b1;
        cyc();
        roi_re = 1'b0;
        chk("roi_udf_flag", err_flags[3], 1);
        chk("roi_empty_after_udf", roi_empty, 1);
        for (int i = 0; i < 5; i++) begin
            roi_in = 48'hA5A5_0000_0000 | 48'(i);
            roi_in_vld = 1'b1;
            if (i < 4) roi_q.push_back(48'hA5A5_0000_0000 | 48'(i));
            cyc();
            if (i == 0) begin
                chk("roi_visible_lat1", roi, 48'hA5A5_0000_0000);
                chk("roi_not_empty", roi_empty, 0);
            end
        end
        roi_in_vld = 1'b0;
        chk("roi_ovf_flag", err_flags[1], 1);
        chk("roi_ovf_no_hit_drop", hit_drop_cnt, 0);
        drain_rois();

        pulse_srst();
        chk("srst_err", err_flags, 0);
        chk("srst_drop", hit_drop_cnt, 0);
        chk("srst_hit_empty", mdt_hit_empty, 1);

        // 33 hits into a 32-deep buffer.
        for (int i = 1; i <= 33; i++) begin
            hit_in = HPS_LSF_LEN'(i);
            hit_in_vld = 1'b1;
            if (i <= 32) hit_q.push_back(HPS_LSF_LEN'(i));
            cyc();
        end
        hit_in_vld = 1'b0;
        chk("full_ovf_flag", err_flags[0], 1);
        chk("full_drop_cnt", hit_drop_cnt, 1);
        drain_hits();

        // Write plus read while full is accepted.
        pulse_srst();
        for (int i = 1; i <= 32; i++) begin
            hit_in = 32'h100 + 32'(i);
            hit_in_vld = 1'b1;
            hit_q.push_back(32'h100 + 32'(i));
            cyc();
        end
        hit_in = 32'hAA;
        mdt_hit_re = 1'b1;
        hit_q.push_back(32'hAA);
        cyc();
        hit_in_vld = 1'b0;
        mdt_hit_re = 1'b0;
        chk("full_wr_re_no_ovf", err_flags[0], 0);
        chk("full_wr_re_no_drop", hit_drop_cnt, 0);
        drain_hits();

        // Cap of two hits per event.
        pulse_srst();
        hit_cap = 10'd2;
        for (int i = 1; i <= 6; i++) begin
            hit_in = 32'h10 + 32'(i);
            hit_in_vld = 1'b1;
            hit_in_last = (i == 5);
            if (i == 1 || i == 2 || i == 6) hit_q.push_back(32'h10 + 32'(i));
            cyc();
        end
        hit_in_vld = 1'b0;
        hit_in_last = 1'b0;
        chk("cap_drop_cnt", hit_drop_cnt, 3);
        drain_hits();

        // Event counter saturates at 1023 instead of wrapping back under the cap.
        pulse_srst();
        hit_cap = 10'd1023;
        mdt_hit_re = 1'b1;
        for (int i = 1; i <= 1030; i++) begin
            hit_in = 32'h1_0000 + 32'(i);
            hit_in_vld = 1'b1;
            if (i <= 1023) hit_q.push_back(32'h1_0000 + 32'(i));
            cyc();
        end
        hit_in_vld = 1'b0;
        cyc();
        mdt_hit_re = 1'b0;
        chk("sat_drop_cnt", hit_drop_cnt, 7);
        chk("sat_queue_drained", hit_q.size(), 0);
        hit_cap = 10'd0;

        // Async reset with ten hits buffered.
        pulse_srst();
        roi_re = 1'b1;
        cyc();
        roi_re = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            hit_in = 32'h200 + 32'(i);
            hit_in_vld = 1'b1;
            cyc();
        end
        hit_in_vld = 1'b0;
        chk("pre_rst_not_empty", mdt_hit_empty, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_empty", mdt_hit_empty, 1);
        chk("async_rst_hit", mdt_hit, 0);
        chk("async_rst_err", err_flags, 0);
        chk("async_rst_drop", hit_drop_cnt, 0);
        hit_in = 32'h55;
        hit_in_vld = 1'b1;
        cyc(); cyc();
        rst = 1'b1;
        hit_in_vld = 1'b0;
        cyc(); cyc(); cyc();
        chk("rst_inputs_ignored", mdt_hit_empty, 1);
        hit_in = 32'h77;
        hit_in_vld = 1'b1;
        cyc();
        hit_in_vld = 1'b0;
        chk("post_rst_lat1_empty", mdt_hit_empty, 0);
        chk("post_rst_lat1_data", mdt_hit, 32'h77);
        hit_q.push_back(32'h77);
        drain_hits();

        chk("final_hit_queue", hit_q.size(), 0);
        chk("final_roi_queue", roi_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
